fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding,
// the buffered fetch entry, and the reset / NOP constants.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0100_0000;
    localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two fetch buffer with synchronous flush; push and pop may coincide at
// any occupancy, including full (the pop frees the slot being written).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset: nothing is visible until r_count says so.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit feeding decode through fetch_fifo.
// Optional: define FETCH_MISALIGN_CHK_EN to trap misaligned redirects instead of aligning them.
// Handshakes: a transfer occurs on a rising edge where valid && ready; the source holds its payload until then.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         f_valid,
    input  logic         f_ready,
    output logic [31:0]  f_pc,
    output logic [31:0]  f_insn,
    output logic         f_misalign,
    output fetch_state_e o_dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  r_state;
    fetch_state_e  w_next_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          r_squash;
    logic          w_squash_next;
    logic          r_misalign;
    logic [31:0]   w_redir_pc;
    logic          w_bad_redir;
    logic          w_credit;
    logic          w_accept;
    logic          w_rsp_push;
    logic          w_fifo_valid;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic [CW-1:0] w_count;

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_redir_pc  = redirect_pc;
    assign w_bad_redir = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign w_bad_redir = 1'b0;
`endif

    // Only one request is ever in flight, and only from WAIT, so in REQ the
    // buffer occupancy alone decides whether a response would still fit.
    assign w_credit       = (w_count < CW'(DEPTH));
    assign imem_req_valid = reset && (r_state == ST_REQ) && w_credit
                            && !redirect_valid && !r_misalign;
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign w_rsp_push     = (r_state == ST_WAIT) && imem_rsp_valid
                            && !r_squash && !redirect_valid;
    assign w_push_data    = '{pc: r_req_pc, insn: imem_rsp_data};

    always_comb begin
        w_next_state  = r_state;
        w_squash_next = r_squash;
        if (redirect_valid) begin
            // A response landing with the redirect retires the old request now.
            if ((r_state == ST_WAIT) && !imem_rsp_valid) begin
                w_next_state  = ST_WAIT;
                w_squash_next = 1'b1;
            end else begin
                w_next_state  = ST_REQ;
                w_squash_next = 1'b0;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (!w_credit && !r_misalign) w_next_state = ST_STALL;
                    else if (w_accept)            w_next_state = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        w_next_state  = ST_REQ;
                        w_squash_next = 1'b0;
                    end
                end
                ST_STALL: begin
                    if (w_credit) w_next_state = ST_REQ;
                end
                default: w_next_state = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_REQ;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_squash   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_squash   <= w_squash_next;
            r_misalign <= r_misalign | w_bad_redir;
            if (redirect_valid) begin
                r_pc <= w_redir_pc;
            end else if (w_accept) begin
                r_pc     <= r_pc + 32'd4;
                r_req_pc <= r_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_rsp_push),
        .i_data  (w_push_data),
        .i_pop   (f_ready),
        .o_valid (w_fifo_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign f_valid     = w_fifo_valid;
    assign f_pc        = w_fifo_valid ? w_head.pc   : 32'd0;
    assign f_insn      = w_fifo_valid ? w_head.insn : 32'd0;
    assign f_misalign  = r_misalign;
    assign o_dbg_state = r_state;

endmodule
